// File: rtl/ld_st_queue_pkg.sv
// Shared types and default sizing for the load/store queue.
package ld_st_queue_pkg;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        PEND   = 2'd1,
        ISSUED = 2'd2,
        DONE   = 2'd3
    } entry_state_e;

    localparam int DEF_DEPTH = 16;
    localparam int DEF_AW    = 32;
    localparam int DEF_DW    = 32;
    localparam int DEF_CW    = 4;
    localparam int DEF_ZW    = 4;

endpackage

// File: rtl/ld_st_queue_fwd_match.sv
// Youngest-first priority select over store candidates lying between head and tail.
module lsq_fwd_match #(
    parameter int DEPTH = 16,
    parameter int IDW   = $clog2(DEPTH)
) (
    input  logic [DEPTH-1:0] cand,
    input  logic [IDW-1:0]   head,
    input  logic [IDW-1:0]   tail,
    input  logic             full,
    output logic             hit,
    output logic [IDW-1:0]   idx
);

    logic [IDW:0]   occ;
    logic [IDW-1:0] pos;

    // Walk from oldest to youngest so the youngest match is the last one written.
    always_comb begin
        occ = full ? (IDW+1)'(DEPTH) : {1'b0, tail - head};
        hit = 1'b0;
        idx = '0;
        pos = '0;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            pos = tail - IDW'(k + 1);
            if (((IDW+1)'(k) < occ) && cand[pos]) begin
                hit = 1'b1;
                idx = pos;
            end
        end
    end

endmodule

// File: rtl/ld_st_queue.sv
// Circular load/store queue: in-order accept and retire, in-order issue, out-of-order completion.
module ld_st_queue
    import ld_st_queue_pkg::*;
#(
    parameter int DEPTH = DEF_DEPTH,
    parameter int AW    = DEF_AW,
    parameter int DW    = DEF_DW,
    parameter int CW    = DEF_CW,
    parameter int ZW    = DEF_ZW
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     req_valid,
    input  logic                     req_rw,
    input  logic [AW-1:0]            req_addr,
    input  logic [DW-1:0]            req_data,
    input  logic [CW-1:0]            req_cntrl,
    input  logic [ZW-1:0]            req_z,
    output logic                     req_ready,
    output logic                     mem_valid,
    output logic                     mem_rw,
    output logic [AW-1:0]            mem_addr,
    output logic [DW-1:0]            mem_data,
    output logic [$clog2(DEPTH)-1:0] mem_id,
    input  logic                     mem_stall,
    input  logic                     rsp_valid,
    input  logic [$clog2(DEPTH)-1:0] rsp_id,
    input  logic [DW-1:0]            rsp_data,
    output logic                     ret_valid,
    output logic                     ret_rw,
    output logic [AW-1:0]            ret_addr,
    output logic [DW-1:0]            ret_data,
    output logic [CW-1:0]            ret_cntrl,
    output logic [ZW-1:0]            ret_z,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty,
    output logic                     full,
    output logic                     fwd_hit
);

    localparam int IDW = $clog2(DEPTH);

    entry_state_e   st_q    [DEPTH];
    entry_state_e   st_d    [DEPTH];
    logic [AW-1:0]  addr_q  [DEPTH];
    logic [AW-1:0]  addr_d  [DEPTH];
    logic [DW-1:0]  data_q  [DEPTH];
    logic [DW-1:0]  data_d  [DEPTH];
    logic [CW-1:0]  cntrl_q [DEPTH];
    logic [CW-1:0]  cntrl_d [DEPTH];
    logic [ZW-1:0]  z_q     [DEPTH];
    logic [ZW-1:0]  z_d     [DEPTH];
    logic [DEPTH-1:0] rw_q, rw_d;

    logic [IDW-1:0] head_q, head_d, tail_q, tail_d, iss_q, iss_d;
    logic [IDW:0]   count_q, count_d;
    logic           full_q, full_d, empty_q, empty_d;

    logic           mem_valid_q, mem_valid_d, mem_rw_q, mem_rw_d;
    logic [AW-1:0]  mem_addr_q, mem_addr_d;
    logic [DW-1:0]  mem_data_q, mem_data_d;
    logic [IDW-1:0] mem_id_q, mem_id_d;

    logic           ret_valid_q, ret_valid_d, ret_rw_q, ret_rw_d;
    logic [AW-1:0]  ret_addr_q, ret_addr_d;
    logic [DW-1:0]  ret_data_q, ret_data_d;
    logic [CW-1:0]  ret_cntrl_q, ret_cntrl_d;
    logic [ZW-1:0]  ret_z_q, ret_z_d;
    logic           fwd_hit_q, fwd_hit_d;

    logic             acc, do_ret, fwd_found;
    logic [DEPTH-1:0] cand;
    logic [IDW-1:0]   fwd_idx;

    assign acc = req_valid && !full_q;

    always_comb begin
        cand = '0;
        for (int i = 0; i < DEPTH; i++)
            cand[i] = (st_q[i] != FREE) && rw_q[i] && (addr_q[i][AW-1:2] == req_addr[AW-1:2]);
    end

    lsq_fwd_match #(.DEPTH(DEPTH), .IDW(IDW)) u_fwd (
        .cand (cand),
        .head (head_q),
        .tail (tail_q),
        .full (full_q),
        .hit  (fwd_found),
        .idx  (fwd_idx)
    );

    // Accept, issue, completion and retire each touch a different entry state,
    // so their writes into the next-state arrays never collide.
    always_comb begin
        st_d        = st_q;
        addr_d      = addr_q;
        data_d      = data_q;
        cntrl_d     = cntrl_q;
        z_d         = z_q;
        rw_d        = rw_q;
        head_d      = head_q;
        tail_d      = tail_q;
        iss_d       = iss_q;
        mem_valid_d = 1'b0;
        mem_rw_d    = mem_rw_q;
        mem_addr_d  = mem_addr_q;
        mem_data_d  = mem_data_q;
        mem_id_d    = mem_id_q;
        ret_valid_d = 1'b0;
        ret_rw_d    = ret_rw_q;
        ret_addr_d  = ret_addr_q;
        ret_data_d  = ret_data_q;
        ret_cntrl_d = ret_cntrl_q;
        ret_z_d     = ret_z_q;
        fwd_hit_d   = 1'b0;
        do_ret      = (st_q[head_q] == DONE);

        if (acc) begin
            rw_d[tail_q]    = req_rw;
            addr_d[tail_q]  = req_addr;
            data_d[tail_q]  = req_data;
            cntrl_d[tail_q] = req_cntrl;
            z_d[tail_q]     = req_z;
            st_d[tail_q]    = PEND;
            if (!req_rw && fwd_found) begin
                data_d[tail_q] = data_q[fwd_idx];
                st_d[tail_q]   = DONE;
                fwd_hit_d      = 1'b1;
            end
            tail_d = tail_q + IDW'(1);
        end

        // Forwarded entries are stepped over even under stall so the issue
        // pointer never falls behind head once they retire.
        if (st_q[iss_q] == PEND && !mem_stall) begin
            mem_valid_d   = 1'b1;
            mem_rw_d      = rw_q[iss_q];
            mem_addr_d    = addr_q[iss_q];
            mem_data_d    = data_q[iss_q];
            mem_id_d      = iss_q;
            st_d[iss_q]   = ISSUED;
            iss_d         = iss_q + IDW'(1);
        end else if (st_q[iss_q] == DONE) begin
            iss_d = iss_q + IDW'(1);
        end

        if (rsp_valid && st_q[rsp_id] == ISSUED) begin
            if (!rw_q[rsp_id])
                data_d[rsp_id] = rsp_data;
            st_d[rsp_id] = DONE;
        end

        if (do_ret) begin
            ret_valid_d  = 1'b1;
            ret_rw_d     = rw_q[head_q];
            ret_addr_d   = addr_q[head_q];
            ret_data_d   = data_q[head_q];
            ret_cntrl_d  = cntrl_q[head_q];
            ret_z_d      = z_q[head_q];
            st_d[head_q] = FREE;
            head_d       = head_q + IDW'(1);
        end

        count_d = count_q + (IDW+1)'(acc) - (IDW+1)'(do_ret);
        full_d  = (count_d == (IDW+1)'(DEPTH));
        empty_d = (count_d == '0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                st_q[i]    <= FREE;
                addr_q[i]  <= '0;
                data_q[i]  <= '0;
                cntrl_q[i] <= '0;
                z_q[i]     <= '0;
            end
            rw_q        <= '0;
            head_q      <= '0;
            tail_q      <= '0;
            iss_q       <= '0;
            count_q     <= '0;
            full_q      <= 1'b0;
            empty_q     <= 1'b1;
            mem_valid_q <= 1'b0;
            mem_rw_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_data_q  <= '0;
            mem_id_q    <= '0;
            ret_valid_q <= 1'b0;
            ret_rw_q    <= 1'b0;
            ret_addr_q  <= '0;
            ret_data_q  <= '0;
            ret_cntrl_q <= '0;
            ret_z_q     <= '0;
            fwd_hit_q   <= 1'b0;
        end else begin
            st_q        <= st_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
            cntrl_q     <= cntrl_d;
            z_q         <= z_d;
            rw_q        <= rw_d;
            head_q      <= head_d;
            tail_q      <= tail_d;
            iss_q       <= iss_d;
            count_q     <= count_d;
            full_q      <= full_d;
            empty_q     <= empty_d;
            mem_valid_q <= mem_valid_d;
            mem_rw_q    <= mem_rw_d;
            mem_addr_q  <= mem_addr_d;
            mem_data_q  <= mem_data_d;
            mem_id_q    <= mem_id_d;
            ret_valid_q <= ret_valid_d;
            ret_rw_q    <= ret_rw_d;
            ret_addr_q  <= ret_addr_d;
            ret_data_q  <= ret_data_d;
            ret_cntrl_q <= ret_cntrl_d;
            ret_z_q     <= ret_z_d;
            fwd_hit_q   <= fwd_hit_d;
        end
    end

    assign req_ready = !full_q;
    assign mem_valid = mem_valid_q;
    assign mem_rw    = mem_rw_q;
    assign mem_addr  = mem_addr_q;
    assign mem_data  = mem_data_q;
    assign mem_id    = mem_id_q;
    assign ret_valid = ret_valid_q;
    assign ret_rw    = ret_rw_q;
    assign ret_addr  = ret_addr_q;
    assign ret_data  = ret_data_q;
    assign ret_cntrl = ret_cntrl_q;
    assign ret_z     = ret_z_q;
    assign count     = count_q;
    assign empty     = empty_q;
    assign full      = full_q;
    assign fwd_hit   = fwd_hit_q;

endmodule

// File: doc/ld_st_queue.md
LD_ST_QUEUE -- requirements
Module: ld_st_queue

Interface
REQ-001 Parameter DEPTH, default 16, entry count; power of two, at least 2.
REQ-002 Parameter AW, default 32, address width; DW, default 32, data width; CW, default 4, control-tag width; ZW, default 4, destination-register width.
REQ-003 Localparam IDW = log2(DEPTH), entry-id width.
REQ-004 clk  in  1  clock; all state updates on rising edge.
REQ-005 rst  in  1  reset; asynchronous, active-high.
REQ-006 req_valid in 1 core request; req_rw in 1 (1 = store); req_addr in AW; req_data in DW; req_cntrl in CW; req_z in ZW.
REQ-007 req_ready out 1, equal to !full; a request is accepted when req_valid && req_ready.
REQ-008 mem_valid out 1; mem_rw out 1; mem_addr out AW; mem_data out DW; mem_id out IDW; mem_stall in 1. These are memory request signals.
REQ-009 rsp_valid in 1; rsp_id in IDW; rsp_data in DW. These are memory completion signals, in any order.
REQ-010 ret_valid out 1; ret_rw out 1; ret_addr out AW; ret_data out DW; ret_cntrl out CW; ret_z out ZW. These are in-order retirement signals to the core.
REQ-011 count out IDW+1 (occupancy); empty out 1; full out 1; fwd_hit out 1 (one-cycle pulse per forwarded load).

Function
REQ-012 Storage is a circular buffer with head, tail and issue pointers of IDW bits; pointers wrap modulo DEPTH.
REQ-013 Each entry is in one of four states: FREE, PEND (awaiting issue), ISSUED, DONE.
REQ-014 On accept, the entry at tail captures rw, addr, data, cntrl and z, moves FREE->PEND, and tail increments.
REQ-015 Forwarding: on accepting a load, the youngest valid older store whose addr[AW-1:2] matches supplies its data; the entry goes directly to DONE, is never sent to memory, and fwd_hit pulses the next cycle.
REQ-016 Issue: when mem_stall is low and the entry at the issue pointer is PEND, the outputs are registered with mem_valid=1 and mem_id equal to the entry index; the entry moves to ISSUED and the issue pointer advances. At most one issue per cycle.
REQ-017 Issue skips entries that are DONE (forwarded); otherwise mem_valid=0 and the other mem outputs hold their values.
REQ-018 While mem_stall is high, no issue occurs and mem_valid is 0 in the following cycle.
REQ-019 Earliest issue is the cycle after accept; issue latency is 1 clock.
REQ-020 Completion: when rsp_valid is high and entry rsp_id is ISSUED, the entry captures rsp_data if it is a load, keeps its own data if it is a store, and moves to DONE.
REQ-021 A response whose rsp_id entry is not ISSUED is ignored with no state change.
REQ-022 Retire: if the head entry is DONE at a rising edge, the ret_* outputs are registered from it with ret_valid=1 for one cycle; the entry moves to FREE and head advances. At most one retire per cycle; otherwise ret_valid=0.
REQ-023 A completion and a retire of the same entry cannot occur on the same edge; a completion makes the entry DONE, and it retires on the next edge.
REQ-024 A simultaneous accept and retire leaves count unchanged.
REQ-025 full = (count == DEPTH) and empty = (count == 0); both are registered and consistent with count.
REQ-026 When full, no request is accepted even if a retire occurs that cycle; the freed slot is usable from the next cycle.
REQ-027 Forwarding compares only entries in PEND, ISSUED or DONE that lie between head and tail, in age order across wrap-around.

Reset
REQ-028 Reset sets all entries to FREE; head, tail, issue pointer and count to 0; empty=1; full=0; req_ready=1.
REQ-029 Reset clears mem_valid, ret_valid and fwd_hit to 0, and clears all data, address, id and tag outputs to 0.
REQ-030 Reset mid-operation discards all entries; responses arriving after reset are ignored per REQ-021.

Structure
REQ-031 A shared package holds the entry-state enumeration (FREE/PEND/ISSUED/DONE) and the default DEPTH, AW, DW, CW and ZW constants.
REQ-032 The forwarding search is a sub-module lsq_fwd_match: a combinational youngest-match priority selector over DEPTH entries, given head and tail.

Verification
REQ-033 Store 0x11 to addr 0x40, then load from 0x40, memory latency 2 -> load retires with data 0x11, fwd_hit pulses once, and only one mem_valid (the store) is seen.
REQ-034 Load A (id 0) then load B (id 1); memory responds id 1 then id 0 -> retirement order A then B, and ret_data matches each response.
REQ-035 Accept 16 requests with no responses (DEPTH=16) -> full=1, req_ready=0, count=16; one response at the head -> one retire, and the next accept is taken the following cycle.
REQ-036 mem_stall held high for 3 cycles with 2 entries PEND -> mem_valid stays 0; after release, ids issue on consecutive cycles.
REQ-037 Wrap-around: 40 mixed loads and stores at DEPTH=4 with random latency -> in-order retirement, correct data, count returns to 0.
REQ-038 Assert rst with 3 entries ISSUED, then a stale response on id 1 -> empty=1, no ret_valid, no state change.
